// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates uids at dispatch, collects out-of-order completions and
// retires one entry per cycle in program order as a registered regfile write.
module rob_commit #(
    parameter int unsigned ROB_BITS = 3,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RADDR_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic                alloc_has_dest,
    input  logic [RADDR_W-1:0]  alloc_waddr,
    output logic                alloc_ready,
    output logic [ROB_BITS-1:0] alloc_uid,
    output logic                change_writer,
    output logic [RADDR_W-1:0]  writer_waddr,
    output logic [ROB_BITS-1:0] new_writer,
    input  logic                cpl_valid,
    input  logic [ROB_BITS-1:0] cpl_uid,
    input  logic [DATA_W-1:0]   cpl_data,
    input  logic                flush,
    output logic                commit_valid,
    output logic [RADDR_W-1:0]  commit_waddr,
    output logic [DATA_W-1:0]   commit_data,
    output logic [ROB_BITS-1:0] commit_uid,
    output logic                retire,
    output logic [ROB_BITS:0]   count
);

    localparam int unsigned Depth = 1 << ROB_BITS;

    logic [ROB_BITS:0]   head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [Depth-1:0]    valid_q, valid_d, done_q, done_d, has_dest_q, has_dest_d;
    logic [RADDR_W-1:0]  waddr_q [Depth];
    logic [RADDR_W-1:0]  waddr_d [Depth];
    logic [DATA_W-1:0]   data_q [Depth];
    logic [DATA_W-1:0]   data_d [Depth];

    logic                commit_valid_q, commit_valid_d, retire_q, retire_d;
    logic [RADDR_W-1:0]  commit_waddr_q, commit_waddr_d;
    logic [DATA_W-1:0]   commit_data_q, commit_data_d;
    logic [ROB_BITS-1:0] commit_uid_q, commit_uid_d;

    logic [ROB_BITS-1:0] head_idx, tail_idx;
    logic                full, alloc_fire, alloc_dest, commit_fire;

    assign head_idx    = head_q[ROB_BITS-1:0];
    assign tail_idx    = tail_q[ROB_BITS-1:0];
    assign full        = (head_idx == tail_idx) && (head_q[ROB_BITS] != tail_q[ROB_BITS]);
    // A retire this cycle does not free a slot until the next cycle.
    assign alloc_ready = !full && !flush && !rst;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_dest  = alloc_has_dest && (alloc_waddr != '0);
    assign commit_fire = valid_q[head_idx] && done_q[head_idx] && !flush && !rst;

    assign alloc_uid     = tail_idx;
    assign change_writer = alloc_fire && alloc_dest;
    assign writer_waddr  = alloc_waddr;
    assign new_writer    = tail_idx;

    assign commit_valid = commit_valid_q;
    assign commit_waddr = commit_waddr_q;
    assign commit_data  = commit_data_q;
    assign commit_uid   = commit_uid_q;
    assign retire       = retire_q;
    assign count        = count_q;

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        valid_d        = valid_q;
        done_d         = done_q;
        has_dest_d     = has_dest_q;
        waddr_d        = waddr_q;
        data_d         = data_q;
        commit_valid_d = 1'b0;
        retire_d       = 1'b0;
        commit_waddr_d = commit_waddr_q;
        commit_data_d  = commit_data_q;
        commit_uid_d   = commit_uid_q;

        // Uses current-state valid, so a completion to a slot allocated this cycle is dropped.
        if (cpl_valid && valid_q[cpl_uid]) begin
            done_d[cpl_uid] = 1'b1;
            data_d[cpl_uid] = cpl_data;
        end

        if (commit_fire) begin
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + 1'b1;
            commit_valid_d    = has_dest_q[head_idx];
            retire_d          = 1'b1;
            commit_waddr_d    = waddr_q[head_idx];
            commit_data_d     = data_q[head_idx];
            commit_uid_d      = head_idx;
        end

        if (alloc_fire) begin
            valid_d[tail_idx]    = 1'b1;
            done_d[tail_idx]     = 1'b0;
            has_dest_d[tail_idx] = alloc_dest;
            waddr_d[tail_idx]    = alloc_waddr;
            tail_d               = tail_q + 1'b1;
        end

        if (alloc_fire && !commit_fire) begin
            count_d = count_q + 1'b1;
        end else if (!alloc_fire && commit_fire) begin
            count_d = count_q - 1'b1;
        end

        if (flush) begin
            valid_d        = '0;
            done_d         = '0;
            head_d         = '0;
            tail_d         = '0;
            count_d        = '0;
            commit_valid_d = 1'b0;
            retire_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            valid_q        <= '0;
            done_q         <= '0;
            has_dest_q     <= '0;
            commit_valid_q <= 1'b0;
            retire_q       <= 1'b0;
            commit_waddr_q <= '0;
            commit_data_q  <= '0;
            commit_uid_q   <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            valid_q        <= valid_d;
            done_q         <= done_d;
            has_dest_q     <= has_dest_d;
            commit_valid_q <= commit_valid_d;
            retire_q       <= retire_d;
            commit_waddr_q <= commit_waddr_d;
            commit_data_q  <= commit_data_d;
            commit_uid_q   <= commit_uid_d;
        end
    end

    // Payload storage needs no reset; it is only read behind valid/done.
    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        data_q  <= data_d;
    end

endmodule
